data_memory_hs: RTL and testbench

Parametrised data memory that succeeds the fixed 32-bit × 64K asynchronous-read memory file. It adds a valid/ready request port, registered reads with configurable latency, byte-lane write enables, an optional clear-on-reset sweep, and a full-word loader port for testbench and boot-image preload. It sits between the datapath's load/store stage and the testbench loader, and is the single storage array for data.

---
 rtl/data_memory_hs.sv | 95 +++++++++
 tb/tb_data_memory_hs.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_hs.sv
// Word-addressed data memory: valid/ready request port, byte-lane writes, full-word loader and clear-on-reset sweep.
// Reads respond READ_LATENCY cycles after accept; req_ready drops only while the clear sweep runs.
module data_memory_hs #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    load_enable,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [DATA_WIDTH-1:0]   load_data,
  output logic                    busy
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clear_addr_q, clear_addr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    pipe_vld_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_dat_q [READ_LATENCY];
  logic                    acc_rd, acc_wr, ld_wr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= CLEAR_ON_RESET ? CLEAR : READY;
      clear_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    req_ready    = 1'b0;
    busy         = 1'b0;
    case (state_q)
      CLEAR: begin
        busy         = 1'b1;
        clear_addr_d = clear_addr_q + 1'b1;
        if (clear_addr_q == '1) state_d = READY;
      end
      READY: req_ready = 1'b1;
    endcase
  end

  // Nothing is accepted while reset is held, even if the state decodes as READY.
  assign acc_rd = reset & req_valid & req_ready & ~req_write;
  assign acc_wr = reset & req_valid & req_ready & req_write;
  assign ld_wr  = reset & load_enable & (state_q == READY);

  // Loader assignment comes last so it owns the whole word on an address collision.
  always_ff @(posedge clk) begin
    if (reset && state_q == CLEAR) mem_q[clear_addr_q] <= '0;
    if (acc_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (req_byte_en[i]) mem_q[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
    if (ld_wr) mem_q[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_vld_q[k] <= 1'b0;
        pipe_dat_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= acc_rd;
      if (acc_rd) pipe_dat_q[0] <= mem_q[req_addr];
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        if (pipe_vld_q[k-1]) pipe_dat_q[k] <= pipe_dat_q[k-1];
      end
    end
  end

  assign rsp_valid = pipe_vld_q[READ_LATENCY-1];
  assign rsp_rdata = pipe_dat_q[READ_LATENCY-1];
endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: instance a (clear sweep, two-cycle reads) and instance b (retained contents, one-cycle reads).
module tb_data_memory_hs;
  localparam int RL_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic        a_reset = 1'b0, a_req_valid = 1'b0, a_req_write = 1'b0, a_load_enable = 1'b0;
  logic [3:0]  a_req_addr = '0, a_req_byte_en = '0, a_load_addr = '0;
  logic [31:0] a_req_wdata = '0, a_load_data = '0;
  logic        a_req_ready, a_rsp_valid, a_busy;
  logic [31:0] a_rsp_rdata;

  logic        b_reset = 1'b0, b_req_valid = 1'b0, b_req_write = 1'b0, b_load_enable = 1'b0;
  logic [3:0]  b_req_addr = '0, b_req_byte_en = '0, b_load_addr = '0;
  logic [31:0] b_req_wdata = '0, b_load_data = '0;
  logic        b_req_ready, b_rsp_valid, b_busy;
  logic [31:0] b_rsp_rdata;

  data_memory_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(RL_A), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_write(a_req_write), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .req_byte_en(a_req_byte_en), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .load_enable(a_load_enable), .load_addr(a_load_addr), .load_data(a_load_data), .busy(a_busy));

  data_memory_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_byte_en(b_req_byte_en), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .load_enable(b_load_enable), .load_addr(b_load_addr), .load_data(b_load_data), .busy(b_busy));

  // Reference model for instance a: word array plus a queue of responses tagged with the tick they are due.
  typedef struct {int due; logic [31:0] dat;} rsp_t;
  logic [31:0] a_mem [16];
  rsp_t        a_q [$];
  int          a_t = 0;
  logic [31:0] a_last = '0;
  bit          a_ready_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_step(input bit v, input bit w, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input bit le, input logic [3:0] la, input logic [31:0] ld);
    rsp_t r;
    bit   exp_v;
    a_req_valid = v; a_req_write = w; a_req_addr = addr; a_req_wdata = wd; a_req_byte_en = be;
    a_load_enable = le; a_load_addr = la; a_load_data = ld;
    chk("a_req_ready", {31'b0, a_req_ready}, {31'b0, a_ready_exp});
    if (a_ready_exp) begin
      if (v && !w) begin
        r.due = a_t + RL_A;
        r.dat = a_mem[addr];
        a_q.push_back(r);
      end
      if (v && w) for (int i = 0; i < 4; i++) if (be[i]) a_mem[addr][8*i +: 8] = wd[8*i +: 8];
      if (le) a_mem[la] = ld;
    end
    @(posedge clk);
    a_t++;
    @(negedge clk);
    a_req_valid = 1'b0; a_req_write = 1'b0; a_load_enable = 1'b0;
    exp_v = (a_q.size() > 0) && (a_q[0].due == a_t);
    chk("a_rsp_valid", {31'b0, a_rsp_valid}, {31'b0, exp_v});
    if (exp_v) begin
      a_last = a_q[0].dat;
      void'(a_q.pop_front());
    end
    chk("a_rsp_rdata", a_rsp_rdata, a_last);
  endtask

  task automatic a_idle();
    a_step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic a_read_expect(input logic [3:0] addr, input bit le, input logic [3:0] la,
                               input logic [31:0] ld, input logic [31:0] exp, input string tag);
    a_step(1'b1, 1'b0, addr, 32'h0, 4'h0, le, la, ld);
    repeat (RL_A - 1) a_idle();
    chk({tag, "_vld"}, {31'b0, a_rsp_valid}, 32'h1);
    chk(tag, a_rsp_rdata, exp);
  endtask

  task automatic a_reset_seq(input int n);
    int cnt;
    a_reset = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("a_rst_vld",   {31'b0, a_rsp_valid}, 32'h0);
      chk("a_rst_rdata", a_rsp_rdata, 32'h0);
      chk("a_rst_busy",  {31'b0, a_busy}, 32'h1);
      chk("a_rst_ready", {31'b0, a_req_ready}, 32'h0);
    end
    a_q.delete();
    a_last = '0;
    a_ready_exp = 1'b0;
    a_reset = 1'b1;
    cnt = 0;
    while (a_busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(posedge clk);
      @(negedge clk);
      chk("a_clr_vld", {31'b0, a_rsp_valid}, 32'h0);
    end
    chk("a_busy_cycles", cnt, 32'd16);
    chk("a_ready_after_clear", {31'b0, a_req_ready}, 32'h1);
    a_ready_exp = 1'b1;
    for (int i = 0; i < 16; i++) a_mem[i] = '0;
  endtask

  task automatic b_cycle(input bit v, input bit w, input logic [3:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input bit le, input logic [3:0] la, input logic [31:0] ld);
    b_req_valid = v; b_req_write = w; b_req_addr = addr; b_req_wdata = wd; b_req_byte_en = be;
    b_load_enable = le; b_load_addr = la; b_load_data = ld;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0; b_req_write = 1'b0; b_load_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    // Instance b: reset values, then retained contents with one-cycle reads.
    chk("b_rst_ready", {31'b0, b_req_ready}, 32'h1);
    chk("b_rst_busy",  {31'b0, b_busy}, 32'h0);
    chk("b_rst_vld",   {31'b0, b_rsp_valid}, 32'h0);
    chk("b_rst_rdata", b_rsp_rdata, 32'h0);
    b_reset = 1'b1;
    chk("b_ready_first", {31'b0, b_req_ready}, 32'h1);
    b_cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h1, 32'hCAFEF00D);
    b_cycle(1'b1, 1'b0, 4'h1, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    chk("b_rd1_vld", {31'b0, b_rsp_valid}, 32'h1);
    chk("b_rd1", b_rsp_rdata, 32'hCAFEF00D);
    b_cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    chk("b_idle_vld", {31'b0, b_rsp_valid}, 32'h0);
    chk("b_hold_rdata", b_rsp_rdata, 32'hCAFEF00D);
    b_cycle(1'b1, 1'b1, 4'h5, 32'h11223344, 4'b1111, 1'b0, 4'h0, 32'h0);
    b_cycle(1'b1, 1'b1, 4'h5, 32'hAABBCCDD, 4'b0101, 1'b0, 4'h0, 32'h0);
    b_cycle(1'b1, 1'b0, 4'h5, 32'h0, 4'h0, 1'b1, 4'h5, 32'h0);
    chk("b_be_rbw", b_rsp_rdata, 32'h11BB33DD);
    b_cycle(1'b1, 1'b0, 4'h5, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    chk("b_after_load", b_rsp_rdata, 32'h0);
    b_reset = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("b_rst2_busy",  {31'b0, b_busy}, 32'h0);
      chk("b_rst2_ready", {31'b0, b_req_ready}, 32'h1);
      chk("b_rst2_rdata", b_rsp_rdata, 32'h0);
    end
    b_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b_rel_ready", {31'b0, b_req_ready}, 32'h1);
    chk("b_rel_busy",  {31'b0, b_busy}, 32'h0);
    b_cycle(1'b1, 1'b0, 4'h1, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    chk("b_retained", b_rsp_rdata, 32'hCAFEF00D);

    // Instance a: power-up clear, preload then reset clears it.
    a_reset_seq(1);
    a_step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h3, 32'hDEADBEEF);
    a_read_expect(4'h3, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, "a_preload");
    a_reset_seq(2);
    a_read_expect(4'h3, 1'b0, 4'h0, 32'h0, 32'h0, "a_cleared");

    a_step(1'b1, 1'b1, 4'h5, 32'h11223344, 4'b1111, 1'b0, 4'h0, 32'h0);
    a_step(1'b1, 1'b1, 4'h5, 32'hAABBCCDD, 4'b0101, 1'b0, 4'h0, 32'h0);
    a_read_expect(4'h5, 1'b0, 4'h0, 32'h0, 32'h11BB33DD, "a_byte_en");

    for (int k = 0; k < 4; k++) a_step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(k), 32'h10 * (k + 1));
    for (int k = 0; k < 4; k++) begin
      a_step(1'b1, 1'b0, 4'(k), 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
      chk("a_b2b_vld", {31'b0, a_rsp_valid}, (k > 0) ? 32'h1 : 32'h0);
      if (k > 0) chk("a_b2b_dat", a_rsp_rdata, 32'h10 * k);
    end
    a_idle();
    chk("a_b2b_last_vld", {31'b0, a_rsp_valid}, 32'h1);
    chk("a_b2b_last_dat", a_rsp_rdata, 32'h40);
    a_idle();
    chk("a_b2b_end_vld", {31'b0, a_rsp_valid}, 32'h0);

    a_step(1'b1, 1'b1, 4'h7, 32'h5555FFFF, 4'hF, 1'b1, 4'h7, 32'hAAAA0000);
    a_read_expect(4'h7, 1'b0, 4'h0, 32'h0, 32'hAAAA0000, "a_collide");
    a_step(1'b1, 1'b1, 4'h8, 32'h12345678, 4'hF, 1'b1, 4'h6, 32'h87654321);
    a_read_expect(4'h8, 1'b0, 4'h0, 32'h0, 32'h12345678, "a_both_req");
    a_read_expect(4'h6, 1'b0, 4'h0, 32'h0, 32'h87654321, "a_both_ld");
    a_step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h9, 32'h1);
    a_read_expect(4'h9, 1'b1, 4'h9, 32'hFFFFFFFF, 32'h1, "a_rbw");
    a_read_expect(4'h9, 1'b0, 4'h0, 32'h0, 32'hFFFFFFFF, "a_wbr");

    a_step(1'b1, 1'b0, 4'h2, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0);
    a_reset_seq(2);

    repeat (400) begin
      a_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             32'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
             4'($urandom_range(0, 15)), 32'($urandom));
    end
    repeat (RL_A + 1) a_idle();
    chk("a_queue_drained", a_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
